key_direction_ctrl: RTL and testbench

KEY_DIRECTION_CTRL -- requirements
Module: key_direction_ctrl

---
 rtl/key_direction_ctrl.sv | 120 ++++++++++++
 tb/tb_key_direction_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_direction_ctrl.sv
// rtl/key_direction_ctrl.sv - debounced four-key direction source with a valid/ready handoff
// Keys are synchronised, debounced, edge-detected, priority-selected, then offered one at a time.
module key_direction_ctrl #(
  parameter int DB_CYCLES = 500000,
  parameter int CNT_W     = $clog2(DB_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_n,
  input  logic       dir_ready,
  input  logic       dir_clear,
  output logic       dir_valid,
  output logic [1:0] dir,
  output logic [1:0] cur_dir,
  output logic       any_press,
  output logic [3:0] key_state
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [3:0]            sync1_q, sync2_q;
  logic [3:0]            level;
  logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]            key_state_q, key_state_d;
  logic [3:0]            ks_prev_q;
  logic [3:0]            press_q;
  logic                  any_press_q;
  logic [1:0]            sel_q, sel_d;
  logic                  dir_valid_q, dir_valid_d;
  logic [1:0]            dir_q, dir_d;
  logic [1:0]            cur_dir_q, cur_dir_d;
  logic                  handshake;
  logic                  accept;
  logic [1:0]            ref_dir;

  assign level = ~sync2_q;

  // A counter only runs while the synchronised level disagrees with the accepted level.
  always_comb begin
    key_state_d = key_state_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (level[i] != key_state_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          key_state_d[i] = level[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Key index doubles as the direction code; the lowest index wins.
  always_comb begin
    sel_d = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (press_q[i]) begin
        sel_d = 2'(i);
      end
    end
  end

  assign handshake = dir_valid_q && dir_ready;
  assign ref_dir   = handshake ? dir_q : cur_dir_q;
  assign accept    = any_press_q && (sel_q != ref_dir) && (sel_q != ~ref_dir);

  always_comb begin
    dir_valid_d = dir_valid_q;
    dir_d       = dir_q;
    cur_dir_d   = cur_dir_q;
    if (dir_clear) begin
      cur_dir_d   = 2'd0;
      dir_valid_d = 1'b0;
    end else begin
      if (handshake) begin
        cur_dir_d   = dir_q;
        dir_valid_d = 1'b0;
      end
      if (accept) begin
        dir_d       = sel_q;
        dir_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '1;
      sync2_q     <= '1;
      cnt_q       <= '0;
      key_state_q <= '0;
      ks_prev_q   <= '0;
      press_q     <= '0;
      any_press_q <= 1'b0;
      sel_q       <= 2'd0;
      dir_valid_q <= 1'b0;
      dir_q       <= 2'd0;
      cur_dir_q   <= 2'd0;
    end else begin
      sync1_q     <= key_n;
      sync2_q     <= sync1_q;
      cnt_q       <= cnt_d;
      key_state_q <= key_state_d;
      ks_prev_q   <= key_state_q;
      press_q     <= key_state_q & ~ks_prev_q;
      any_press_q <= |press_q;
      sel_q       <= sel_d;
      dir_valid_q <= dir_valid_d;
      dir_q       <= dir_d;
      cur_dir_q   <= cur_dir_d;
    end
  end

  assign dir_valid = dir_valid_q;
  assign dir       = dir_q;
  assign cur_dir   = cur_dir_q;
  assign any_press = any_press_q;
  assign key_state = key_state_q;

endmodule

// File: tb/tb_key_direction_ctrl.sv
// tb/tb_key_direction_ctrl.sv - scoreboard bench for key_direction_ctrl
// A per-edge behavioural model predicts outputs; a monitor compares them every cycle.
module tb_key_direction_ctrl;

  localparam int DB = 4;

  logic       clk;
  logic       rst;
  logic [3:0] key_n;
  logic       dir_ready;
  logic       dir_clear;
  logic       dir_valid;
  logic [1:0] dir;
  logic [1:0] cur_dir;
  logic       any_press;
  logic [3:0] key_state;

  key_direction_ctrl #(.DB_CYCLES(DB)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_n     (key_n),
    .dir_ready (dir_ready),
    .dir_clear (dir_clear),
    .dir_valid (dir_valid),
    .dir       (dir),
    .cur_dir   (cur_dir),
    .any_press (any_press),
    .key_state (key_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] ks;
    logic [1:0] cur;
    logic       dv;
    logic [1:0] dir;
    logic       ap;
  } snap_t;

  snap_t exp_q[$];

  int checks   = 0;
  int failures = 0;
  int ap_cnt   = 0;
  int dv_cnt   = 0;

  // Model state: raw key history, debounced levels, stable-run lengths, rise history, handoff.
  logic [3:0] m_h1 = '1, m_h2 = '1;
  logic [3:0] m_deb = '0;
  int         m_run[4] = '{0, 0, 0, 0};
  logic [3:0] m_r1 = '0, m_r2 = '0, m_r3 = '0;
  logic       m_dv = 1'b0;
  logic [1:0] m_dir = 2'd0;
  logic [1:0] m_cur = 2'd0;
  logic       m_ap = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic model_edge(input logic [3:0] kn, input logic rdy, input logic clr, input logic r);
    logic [3:0] lvl, old_deb;
    int sel, refd;
    bit hs;
    snap_t s;
    if (r) begin
      m_h1 = '1; m_h2 = '1; m_deb = '0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      m_r1 = '0; m_r2 = '0; m_r3 = '0;
      m_dv = 1'b0; m_dir = 2'd0; m_cur = 2'd0; m_ap = 1'b0;
    end else begin
      m_ap = (m_r2 != 4'd0);
      hs   = m_dv && rdy;
      refd = hs ? int'(m_dir) : int'(m_cur);
      sel  = -1;
      for (int i = 0; i < 4; i++) if (m_r3[i] && sel < 0) sel = i;
      if (clr) begin
        m_cur = 2'd0;
        m_dv  = 1'b0;
      end else begin
        if (hs) begin
          m_cur = m_dir;
          m_dv  = 1'b0;
        end
        if (sel >= 0 && sel != refd && sel + refd != 3) begin
          m_dir = 2'(sel);
          m_dv  = 1'b1;
        end
      end
      lvl     = ~m_h2;
      old_deb = m_deb;
      for (int i = 0; i < 4; i++) begin
        if (lvl[i] != m_deb[i]) begin
          m_run[i]++;
          if (m_run[i] == DB) begin
            m_deb[i] = lvl[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_h2 = m_h1; m_h1 = kn;
      m_r3 = m_r2; m_r2 = m_r1; m_r1 = m_deb & ~old_deb;
    end
    s.ks = m_deb; s.cur = m_cur; s.dv = m_dv; s.dir = m_dir; s.ap = m_ap;
    exp_q.push_back(s);
  endtask

  task automatic cyc(input logic [3:0] kn, input logic rdy, input logic clr, input logic r);
    key_n     = kn;
    dir_ready = rdy;
    dir_clear = clr;
    rst       = r;
    model_edge(kn, rdy, clr, r);
    @(posedge clk);
    #2;
    if (any_press) ap_cnt++;
    if (dir_valid) dv_cnt++;
  endtask

  task automatic press(input logic [3:0] kn);
    repeat (12) cyc(kn, 1'b0, 1'b0, 1'b0);
    repeat (8) cyc(4'hF, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin : monitor
    snap_t s;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        s = exp_q.pop_front();
        chk("mon_key_state", key_state, s.ks);
        chk("mon_cur_dir", cur_dir, s.cur);
        chk("mon_dir_valid", dir_valid, s.dv);
        chk("mon_dir", dir, s.dir);
        chk("mon_any_press", any_press, s.ap);
      end
    end
  end

  initial begin : driver
    repeat (3) cyc(4'hF, 1'b0, 1'b0, 1'b1);
    chk("rst_dir_valid", dir_valid, 0);
    chk("rst_dir", dir, 0);
    chk("rst_cur_dir", cur_dir, 0);
    chk("rst_any_press", any_press, 0);
    chk("rst_key_state", key_state, 0);

    ap_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      cyc(4'b1101, 1'b0, 1'b0, 1'b0);
      if (i == 8) chk("down_valid_early", dir_valid, 0);
      if (i == 9) begin
        chk("down_valid_cycle8", dir_valid, 1);
        chk("down_dir", dir, 2'b01);
      end
    end
    chk("down_single_press", ap_cnt, 1);
    chk("down_key_state", key_state, 4'b0010);
    repeat (10) cyc(4'hF, 1'b0, 1'b0, 1'b0);
    chk("release_no_event_dv", dir_valid, 1);

    cyc(4'hF, 1'b1, 1'b1, 1'b0);
    chk("clear_wins_cur", cur_dir, 0);
    chk("clear_wins_dv", dir_valid, 0);

    ap_cnt = 0; dv_cnt = 0;
    press(4'b0111);
    chk("left_reversal_dv", dv_cnt, 0);
    chk("left_press_seen", ap_cnt, 1);
    press(4'b1011);
    chk("up_dir", dir, 2'b10);
    chk("up_dv", dir_valid, 1);

    press(4'b1101);
    chk("stall_down_dir", dir, 2'b01);
    press(4'b1110);
    chk("stall_right_discard", dir, 2'b01);
    press(4'b1011);
    chk("stall_up_dir", dir, 2'b10);
    cyc(4'hF, 1'b1, 1'b0, 1'b0);
    chk("handshake_cur", cur_dir, 2'b10);
    chk("handshake_dv", dir_valid, 0);

    ap_cnt = 0;
    cyc(4'b1100, 1'b0, 1'b0, 1'b0);
    cyc(4'hF, 1'b0, 1'b0, 1'b0);
    cyc(4'b1100, 1'b0, 1'b0, 1'b0);
    cyc(4'hF, 1'b0, 1'b0, 1'b0);
    press(4'b1100);
    chk("bounce_one_event", ap_cnt, 1);
    chk("bounce_right_wins", dir, 2'b00);
    chk("bounce_dv", dir_valid, 1);

    cyc(4'hF, 1'b0, 1'b0, 1'b1);
    chk("midrst_dv", dir_valid, 0);
    chk("midrst_dir", dir, 0);
    chk("midrst_cur", cur_dir, 2'b00);
    chk("midrst_ks", key_state, 0);

    repeat (3) cyc(4'b1101, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 12; i++) begin
      cyc(4'b1101, 1'b0, 1'b0, 1'b0);
      if (i == 8) chk("held_rst_early", dir_valid, 0);
    end
    chk("held_rst_dv", dir_valid, 1);
    chk("held_rst_dir", dir, 2'b01);
    repeat (8) cyc(4'hF, 1'b0, 1'b0, 1'b0);

    for (int seg = 0; seg < 300; seg++) begin
      logic [3:0] kn;
      int len;
      case ($urandom_range(0, 3))
        0:       kn = 4'hF;
        1:       kn = ~(4'b0001 << $urandom_range(0, 3));
        default: kn = 4'($urandom);
      endcase
      len = $urandom_range(1, 12);
      for (int j = 0; j < len; j++) begin
        cyc(kn, $urandom_range(0, 2) == 0, $urandom_range(0, 40) == 0,
            $urandom_range(0, 250) == 0);
      end
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
